instr_encoder: RTL and testbench
================================

# instr_encoder

Assembles LEGv8 instruction fields into 32-bit machine words and writes them sequentially into instruction memory. It is the inverse of the decode stage: the decode stage splits an instruction into fields, and this block packs fields into one. It lets benches and the boot path load programs field-by-field instead of writing hand-assembled hex. It sits between a field source (testbench or loader) and the instruction-memory write port.

## Interface
- ADDR_W, 6, instruction-memory word-address width (memory depth is 2^ADDR_W words)
- clk  in  1  the single clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  field set presented
- in_ready  out  1  block accepts a field set this cycle
- fmt  in  3  format select: 0=R, 1=I, 2=D, 3=B, 4=CB, 5=IW; codes 6 and 7 are illegal
- opcode  in  11  opcode, MSB-aligned; the format uses only its top bits
- rd  in  5  Rd, or Rt for D and CB formats
- rn  in  5  Rn
- rm  in  5  Rm
- shamt  in  6  shift amount (R format); bits [1:0] are the hw field (IW format)
- imm  in  26  immediate or address field, LSB-aligned
- load_addr  in  1  load the write pointer from start_addr
- start_addr  in  ADDR_W  new value for the write pointer
- imem_we  out  1  memory write request
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction word
- imem_ack  in  1  memory accepted the write
- count  out  ADDR_W+1  words written since reset; wraps
- wrapped  out  1  sticky; set when the write pointer rolls over
- err  out  1  sticky; set on an illegal fmt, or on a range violation (when the range check is compiled in)

## Operation
- Field packing by format:
  - R: {opcode[10:0], rm, shamt, rn, rd}
  - I: {opcode[10:1], imm[11:0], rn, rd}
  - D: {opcode[10:0], imm[8:0], 2'b00, rn, rd}
  - B: {opcode[10:5], imm[25:0]}
  - CB: {opcode[10:3], imm[18:0], rd}
  - IW: {opcode[10:2], shamt[1:0], imm[15:0], rd}
- FSM states:
  - IDLE: waits for a field set.
  - WRITE: holds the write request until the memory acknowledges it.
- in_ready = (state==IDLE) & ~load_addr.
- In IDLE with load_addr=1: the pointer is set to start_addr. load_addr has priority over in_valid that cycle.
- Accept (in_valid & in_ready, legal fmt):
  - register imem_wdata and imem_addr = pointer;
  - go to WRITE.
- Accept with an illegal fmt: set err, write nothing, stay in IDLE.
- In WRITE:
  - imem_we=1 with addr and wdata held stable.
  - The edge that samples imem_ack=1: pointer+1 (modulo 2^ADDR_W), count+1, return to IDLE.
  - Pointer rolling from 2^ADDR_W-1 to 0 sets wrapped.
- load_addr and in_valid are ignored while in WRITE.
- Reset values: state=IDLE, pointer=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, wrapped=0, err=0. in_ready=1 once rst_n is high.

## Timing
- Accept edge T: imem_we=1 is visible in the cycle after T.
- imem_ack high in that same cycle: imem_we=0 and in_ready=1 in the following cycle.
- Minimum of 2 cycles per word; each cycle of imem_ack low adds one.
- imem_ack while in IDLE is ignored.
- Reset mid-write (rst_n low at the edge): imem_we=0 after that edge, the word is dropped, no count update.
- err and wrapped clear only on reset.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined: on accept, check imm against its field width.
  - Unsigned fields: I 12-bit, IW 16-bit.
  - Signed fields: D 9-bit, CB 19-bit, B 26-bit (the bits above the field must equal its sign bit).
  - Out of range: set err, drop the word, stay in IDLE.
- Macro undefined: no check; imm is truncated to the field width silently.

## Test plan
- ADD X3,X1,X2: fmt=0, opcode=11'h458, rm=2, rn=1, rd=3 -> one write, imem_wdata=32'h8B020023 at addr 0, count=1.
- ADDI X9,X9,#1: fmt=1, opcode=11'h488, imm=1, rn=9, rd=9 -> 32'h91000529. Hold imem_ack low 3 cycles -> imem_we held 4 cycles with data stable, in_ready low throughout.
- LDUR X10,[X1,#8] -> 32'hF840802A. B #3 (opcode=11'h0A0) -> 32'h14000003. CBZ X1,#-2 (opcode=11'h5A0, imm=26'h3FFFFFE, rd=1) -> 32'hB4FFFFC1.
- load_addr with start_addr=63 and in_valid high in the same cycle -> in_ready=0, pointer=63. Then two writes -> addresses 63 and 0, wrapped=1, count=2.
- fmt=7 -> err=1, imem_we never asserted. rst_n low during WRITE -> imem_we=0 and all outputs return to their reset values.
- ADDI with imm=26'h1000 -> with INSTR_ENC_RANGE_CHECK_EN: err=1, no write. Without it: word written as 32'h91000129 (rn=9, rd=9).

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-source and instruction-memory write-port bundle for instr_encoder.
// master = field source / memory model side, slave = the encoder itself.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [10:0]       opcode;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [5:0]        shamt;
    logic [25:0]       imm;
    logic              load_addr;
    logic [ADDR_W-1:0] start_addr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;
    logic [ADDR_W:0]   count;
    logic              wrapped;
    logic              err;

    modport master (
        output in_valid, fmt, opcode, rd, rn, rm, shamt, imm,
               load_addr, start_addr, imem_ack,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, wrapped, err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rn, rm, shamt, imm,
               load_addr, start_addr, imem_ack,
        output in_ready, imem_we, imem_addr, imem_wdata, count, wrapped, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs LEGv8 instruction fields into 32-bit words and writes them sequentially to imem.
// Optional: define INSTR_ENC_RANGE_CHECK_EN to reject immediates that do not fit their field.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_encoder_if.slave    bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [ADDR_W:0]   count_r;
    logic              wrapped_r;
    logic              err_r;
    logic              accept_s;
    logic              legal_s;
    logic              in_range_s;
    logic [31:0]       word_s;

    function automatic logic [31:0] pack_word(
        input logic [2:0]  f,
        input logic [10:0] op,
        input logic [4:0]  rd,
        input logic [4:0]  rn,
        input logic [4:0]  rm,
        input logic [5:0]  sh,
        input logic [25:0] im
    );
        logic [31:0] w;
        case (f)
            3'd0:    w = {op[10:0], rm, sh, rn, rd};
            3'd1:    w = {op[10:1], im[11:0], rn, rd};
            3'd2:    w = {op[10:0], im[8:0], 2'b00, rn, rd};
            3'd3:    w = {op[10:5], im[25:0]};
            3'd4:    w = {op[10:3], im[18:0], rd};
            3'd5:    w = {op[10:2], sh[1:0], im[15:0], rd};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // Unsigned fields need zero upper bits; signed fields need upper bits equal to the sign bit.
    function automatic logic imm_fits(input logic [2:0] f, input logic [25:0] im);
        logic ok;
        case (f)
            3'd1:    ok = (im[25:12] == 14'd0);
            3'd5:    ok = (im[25:16] == 10'd0);
            3'd2:    ok = (im[25:9] == {17{im[8]}});
            3'd4:    ok = (im[25:19] == {7{im[18]}});
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    assign in_range_s = imm_fits(bus.fmt, bus.imm);
`else
    assign in_range_s = 1'b1;
`endif

    assign legal_s  = (bus.fmt <= 3'd5);
    assign accept_s = bus.in_valid & bus.in_ready;
    assign word_s   = pack_word(bus.fmt, bus.opcode, bus.rd, bus.rn, bus.rm, bus.shamt, bus.imm);

    assign bus.in_ready   = (state_r == ST_IDLE) & ~bus.load_addr;
    assign bus.imem_we    = (state_r == ST_WRITE);
    assign bus.imem_addr  = addr_r;
    assign bus.imem_wdata = wdata_r;
    assign bus.count      = count_r;
    assign bus.wrapped    = wrapped_r;
    assign bus.err        = err_r;

    // Next-state logic: a legal, in-range accept starts a write; ack ends it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s && in_range_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (bus.imem_ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus pointer, captured word, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {ADDR_W{1'b0}};
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= 32'd0;
            count_r   <= {(ADDR_W+1){1'b0}};
            wrapped_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.load_addr) begin
                        ptr_r <= bus.start_addr;
                    end else if (accept_s) begin
                        if (legal_s && in_range_s) begin
                            addr_r  <= ptr_r;
                            wdata_r <= word_s;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.imem_ack) begin
                        ptr_r   <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
                        if (&ptr_r) begin
                            wrapped_r <= 1'b1;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected (addr, word) pairs are queued when a
// field set is driven and compared when the memory handshake completes.
module tb_instr_encoder;
    localparam int ADDR_W = 6;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_ptr;
    logic [ADDR_W:0]    exp_count;
    logic               exp_wrapped;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory-side monitor: a completed handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.imem_we && bus.imem_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {26'd0, bus.imem_addr, bus.imem_wdata}, 64'd0);
            end else begin
                check("write_addr_data", {26'd0, bus.imem_addr, bus.imem_wdata},
                      {26'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.fmt        = 3'd0;
        bus.opcode     = 11'd0;
        bus.rd         = 5'd0;
        bus.rn         = 5'd0;
        bus.rm         = 5'd0;
        bus.shamt      = 6'd0;
        bus.imm        = 26'd0;
        bus.load_addr  = 1'b0;
        bus.start_addr = 6'd0;
        bus.imem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        exp_ptr     = 6'd0;
        exp_count   = 7'd0;
        exp_wrapped = 1'b0;
    endtask

    task automatic drive(input logic [2:0] f, input logic [10:0] op, input logic [4:0] d,
                         input logic [4:0] n, input logic [4:0] m, input logic [5:0] sh,
                         input logic [25:0] im);
        bus.fmt    = f;
        bus.opcode = op;
        bus.rd     = d;
        bus.rn     = n;
        bus.rm     = m;
        bus.shamt  = sh;
        bus.imm    = im;
    endtask

    // Accept one field set, hold ack low for ack_wait cycles, then complete the write.
    task automatic send(input string tag, input logic [2:0] f, input logic [10:0] op,
                        input logic [4:0] d, input logic [4:0] n, input logic [4:0] m,
                        input logic [5:0] sh, input logic [25:0] im, input int ack_wait,
                        input logic [31:0] exp_word);
        drive(f, op, d, n, m, sh, im);
        bus.in_valid = 1'b1;
        #1;
        check({tag, "_ready_before"}, {63'd0, bus.in_ready}, 64'd1);
        exp_q.push_back({exp_ptr, exp_word});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < ack_wait; i++) begin
            check({tag, "_we_held"}, {63'd0, bus.imem_we}, 64'd1);
            check({tag, "_data_stable"}, {32'd0, bus.imem_wdata}, {32'd0, exp_word});
            check({tag, "_ready_low"}, {63'd0, bus.in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        check({tag, "_we"}, {63'd0, bus.imem_we}, 64'd1);
        bus.imem_ack = 1'b1;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        if (exp_ptr == 6'd63) exp_wrapped = 1'b1;
        exp_ptr   = exp_ptr + 6'd1;
        exp_count = exp_count + 7'd1;
        check({tag, "_we_after"}, {63'd0, bus.imem_we}, 64'd0);
        check({tag, "_ready_after"}, {63'd0, bus.in_ready}, 64'd1);
        check({tag, "_count"}, {57'd0, bus.count}, {57'd0, exp_count});
        check({tag, "_wrapped"}, {63'd0, bus.wrapped}, {63'd0, exp_wrapped});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        do_reset();
        #1;
        check("rst_we", {63'd0, bus.imem_we}, 64'd0);
        check("rst_addr", {58'd0, bus.imem_addr}, 64'd0);
        check("rst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
        check("rst_count", {57'd0, bus.count}, 64'd0);
        check("rst_flags", {62'd0, bus.wrapped, bus.err}, 64'd0);
        check("rst_ready", {63'd0, bus.in_ready}, 64'd1);

        // Main packing across all formats, with and without ack stalls.
        send("add",  3'd0, 11'h458, 5'd3,  5'd1,  5'd2, 6'd0, 26'd0,        0, 32'h8B020023);
        send("addi", 3'd1, 11'h488, 5'd9,  5'd9,  5'd0, 6'd0, 26'd1,        3, 32'h91000529);
        send("ldur", 3'd2, 11'h7C2, 5'd10, 5'd1,  5'd0, 6'd0, 26'd8,        1, 32'hF840802A);
        send("b",    3'd3, 11'h0A0, 5'd0,  5'd0,  5'd0, 6'd0, 26'd3,        0, 32'h14000003);
        send("cbz",  3'd4, 11'h5A0, 5'd1,  5'd0,  5'd0, 6'd0, 26'h3FFFFFE,  2, 32'hB4FFFFC1);
        send("movz", 3'd5, 11'h694, 5'd5,  5'd0,  5'd0, 6'd1, 26'h0001234,  0, 32'hD2A24685);

        // Ack while idle must not count anything.
        bus.imem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        check("idle_ack_count", {57'd0, bus.count}, {57'd0, exp_count});
        check("idle_ack_we", {63'd0, bus.imem_we}, 64'd0);

        // load_addr beats in_valid, then two writes roll the pointer over.
        do_reset();
        drive(3'd0, 11'h458, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
        bus.load_addr  = 1'b1;
        bus.start_addr = 6'd63;
        bus.in_valid   = 1'b1;
        #1;
        check("load_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        bus.load_addr = 1'b0;
        bus.in_valid  = 1'b0;
        exp_ptr = 6'd63;
        check("load_no_we", {63'd0, bus.imem_we}, 64'd0);
        send("wrap0", 3'd0, 11'h458, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 0, 32'h8B020023);
        send("wrap1", 3'd3, 11'h0A0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd3, 1, 32'h14000003);

        // Illegal format sets err and writes nothing.
        do_reset();
        drive(3'd7, 11'h458, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("illegal_err", {63'd0, bus.err}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("illegal_no_we", {63'd0, bus.imem_we}, 64'd0);
            @(posedge clk); #1;
        end
        check("illegal_err_sticky", {63'd0, bus.err}, 64'd1);
        check("illegal_count", {57'd0, bus.count}, 64'd0);

        // Oversized I-format immediate.
        do_reset();
`ifdef INSTR_ENC_RANGE_CHECK_EN
        drive(3'd1, 11'h488, 5'd9, 5'd9, 5'd0, 6'd0, 26'h0001000);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("range_err", {63'd0, bus.err}, 64'd1);
        check("range_no_we", {63'd0, bus.imem_we}, 64'd0);
`else
        send("trunc", 3'd1, 11'h488, 5'd9, 5'd9, 5'd0, 6'd0, 26'h0001000, 0, 32'h91000129);
        check("trunc_no_err", {63'd0, bus.err}, 64'd0);
`endif

        // Reset during a stalled write drops the word.
        do_reset();
        drive(3'd1, 11'h488, 5'd9, 5'd9, 5'd0, 6'd0, 26'd1);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("midrst_we_before", {63'd0, bus.imem_we}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_we", {63'd0, bus.imem_we}, 64'd0);
        check("midrst_addr", {58'd0, bus.imem_addr}, 64'd0);
        check("midrst_wdata", {32'd0, bus.imem_wdata}, 64'd0);
        check("midrst_count", {57'd0, bus.count}, 64'd0);
        check("midrst_flags", {62'd0, bus.wrapped, bus.err}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", {63'd0, bus.in_ready}, 64'd1);
        exp_ptr     = 6'd0;
        exp_count   = 7'd0;
        exp_wrapped = 1'b0;
        send("after_rst", 3'd0, 11'h458, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 0, 32'h8B020023);

        @(posedge clk); #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
